csr_ctrl: RTL and testbench
===========================

CSR_CTRL -- requirements
Module: csr_ctrl

Interface
REQ-001 SHALL: clk  input  1  clock; one clock domain, all state updates on posedge clk.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: req_valid/req_ready  input/output  1/1  commit-request handshake from pipeline.
REQ-004 SHALL: req_op  input  3  op code: NONE=0, CSRRD=1, CSRWR=2, CSRXCHG=3, ERTN=4, SYSCALL=5, BREAK=6.
REQ-005 SHALL: req_pc, req_csr_num, req_rd_val, req_rj_val, req_badv  inputs  32/14/32/32/32  instruction pc, CSR number, rd operand, rj mask operand, faulting address.
REQ-006 SHALL: req_exc_adef, req_exc_ine, req_exc_ale, req_exc_adem  inputs  1 each  exception flags from earlier stages.
REQ-007 SHALL: resp_valid/resp_ready  output/input  1/1  completion handshake.
REQ-008 SHALL: resp_rd_val, resp_redirect, resp_target  outputs  32/1/32  old CSR value, flush request, redirect pc.
REQ-009 SHALL: csr_addr, csr_we, csr_wdata  outputs  14/32/32  CSR file access port; csr_rdata  input  32.
REQ-010 SHALL: csr_have_exception, csr_ertn, csr_exception_type (exception_t), csr_pc_in (32), csr_badv_we, csr_badv_data (32)  outputs; csr_pc_out (32), csr_interrupt (1)  inputs.

Function
REQ-011 SHALL: FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-012 SHALL: req_ready=1 only in IDLE; accept on req_valid&&req_ready; latch all req fields plus csr_interrupt, go EXEC.
REQ-013 SHALL: EXEC lasts exactly one cycle, then RESP; resp_valid=1 only in RESP, held with stable payload until resp_ready, then IDLE.
REQ-014 SHALL: accept-to-resp_valid latency = 2 cycles with resp_ready=1 (back-to-back throughput one request per 3 cycles).
REQ-015 SHALL: exception priority in EXEC: latched interrupt (Ecode 0x0) > ADEF (0x8,sub 0) > INE (0xD) > SYSCALL (0xB) / BREAK (0xC) > ALE (0x9) > ADEM (0x8,sub 1).
REQ-016 SHALL: on exception, EXEC drives csr_have_exception=1, csr_ertn=0, csr_exception_type={Ecode,EsubCode}, csr_pc_in=latched pc, csr_we=0, for one cycle only.
REQ-017 SHALL: ADEF sets csr_badv_we=1, csr_badv_data=pc; ALE/ADEM set csr_badv_we=1, csr_badv_data=req_badv; others badv_we=0.
REQ-018 SHALL: exception response: resp_redirect=1, resp_target=csr_pc_out sampled in EXEC (EENTRY); resp_rd_val=0; instruction side effects suppressed.
REQ-019 SHALL: ERTN without exception: EXEC drives csr_have_exception=1, csr_ertn=1; resp_target=csr_pc_out (ERA), resp_redirect=1.
REQ-020 SHALL: CSRRD: csr_addr=csr_num, csr_we=0; resp_rd_val=csr_rdata sampled in EXEC; resp_redirect=0.
REQ-021 SHALL: CSRWR: csr_we=32'hFFFF_FFFF, csr_wdata=rd_val; CSRXCHG: csr_we=rj_val, csr_wdata=rd_val; both return pre-write csr_rdata and resp_redirect=1, resp_target=pc+4 (mod 2^32).
REQ-022 SHALL: CSRXCHG with rj_val=0 still redirects; csr_we is all-zero that cycle.
REQ-023 SHALL: NONE without exception: no CSR activity, resp_redirect=0.
REQ-024 SHALL: outside EXEC, csr_we=0, csr_have_exception=0, csr_ertn=0, csr_badv_we=0; csr_addr holds latched number.
REQ-025 SHALL: csr_interrupt changes after accept do not affect the in-flight request.

Reset
REQ-026 SHALL: reset from any state returns IDLE next cycle, aborting in-flight request with no CSR side effect that cycle.
REQ-027 SHALL: reset values: req_ready=0 during reset then 1, resp_valid=0, all csr strobes 0, resp payload 0, csr_addr=0.

Structure
REQ-028 SHALL: exception_t, Ecode/EsubCode constants and req_op enum live in the shared definitions package.
REQ-029 SHALL: one sub-module exc_prio (combinational priority encoder of flags to exception_t plus valid); rest flat.

Verification
REQ-030 SHALL: CSRRD num 0x30, csr_rdata=0x1234_5678 -> resp_rd_val=0x1234_5678, csr_we=0 all cycles, redirect=0.
REQ-031 SHALL: CSRXCHG num 0x00, rd=0x7, rj=0x3, old=0xB -> one-cycle csr_we=0x3, wdata=0x7; resp_rd_val=0xB, target=pc+4.
REQ-032 SHALL: SYSCALL pc=0x1C00_0100, pc_out=0x1C00_8000 -> have_exception one cycle, type Ecode 0xB, pc_in=0x1C00_0100, target=0x1C00_8000.
REQ-033 SHALL: CSRWR with interrupt=1 at accept and ale=1 -> Ecode 0x0 taken, csr_we=0, badv_we=0.
REQ-034 SHALL: resp_ready low 5 cycles -> resp payload stable, req_ready=0; reset in EXEC -> no strobes, IDLE next cycle.
REQ-035 SHALL: ALE with req_badv=0x8000_0003 -> badv_we=1, badv_data=0x8000_0003, Ecode 0x9; ERTN -> ertn=1, target=ERA value.

Source files
------------

// File: rtl/csr_ctrl_pkg.sv
// Shared types for the CSR commit controller: op codes, exception encoding, FSM states.
package csr_ctrl_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CSR_NUM_W = 14;
    localparam int unsigned ECODE_W   = 6;
    localparam int unsigned ESUB_W    = 9;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_CSRRD   = 3'd1,
        OP_CSRWR   = 3'd2,
        OP_CSRXCHG = 3'd3,
        OP_ERTN    = 3'd4,
        OP_SYSCALL = 3'd5,
        OP_BREAK   = 3'd6
    } req_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [ECODE_W-1:0] ecode;
        logic [ESUB_W-1:0]  esubcode;
    } exception_t;

    localparam logic [ECODE_W-1:0] ECODE_INT = 6'h00;
    localparam logic [ECODE_W-1:0] ECODE_ADE = 6'h08;
    localparam logic [ECODE_W-1:0] ECODE_ALE = 6'h09;
    localparam logic [ECODE_W-1:0] ECODE_SYS = 6'h0B;
    localparam logic [ECODE_W-1:0] ECODE_BRK = 6'h0C;
    localparam logic [ECODE_W-1:0] ECODE_INE = 6'h0D;

    localparam logic [ESUB_W-1:0] ESUB_NONE = 9'd0;
    localparam logic [ESUB_W-1:0] ESUB_ADEF = 9'd0;
    localparam logic [ESUB_W-1:0] ESUB_ADEM = 9'd1;

    function automatic exception_t mk_exc(input logic [ECODE_W-1:0] ecode,
                                          input logic [ESUB_W-1:0]  esubcode);
        exception_t e;
        e.ecode    = ecode;
        e.esubcode = esubcode;
        return e;
    endfunction

endpackage

// File: rtl/csr_ctrl_if.sv
// Pipeline request/response handshake plus CSR file access port of the CSR controller.
interface csr_ctrl_if;
    import csr_ctrl_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    req_op_e               req_op;
    logic [XLEN-1:0]       req_pc;
    logic [CSR_NUM_W-1:0]  req_csr_num;
    logic [XLEN-1:0]       req_rd_val;
    logic [XLEN-1:0]       req_rj_val;
    logic [XLEN-1:0]       req_badv;
    logic                  req_exc_adef;
    logic                  req_exc_ine;
    logic                  req_exc_ale;
    logic                  req_exc_adem;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [XLEN-1:0]       resp_rd_val;
    logic                  resp_redirect;
    logic [XLEN-1:0]       resp_target;

    logic [CSR_NUM_W-1:0]  csr_addr;
    logic [XLEN-1:0]       csr_we;
    logic [XLEN-1:0]       csr_wdata;
    logic [XLEN-1:0]       csr_rdata;
    logic                  csr_have_exception;
    logic                  csr_ertn;
    exception_t            csr_exception_type;
    logic [XLEN-1:0]       csr_pc_in;
    logic                  csr_badv_we;
    logic [XLEN-1:0]       csr_badv_data;
    logic [XLEN-1:0]       csr_pc_out;
    logic                  csr_interrupt;

    modport master (
        output req_valid, req_op, req_pc, req_csr_num, req_rd_val, req_rj_val, req_badv,
               req_exc_adef, req_exc_ine, req_exc_ale, req_exc_adem, resp_ready,
               csr_rdata, csr_pc_out, csr_interrupt,
        input  req_ready, resp_valid, resp_rd_val, resp_redirect, resp_target,
               csr_addr, csr_we, csr_wdata, csr_have_exception, csr_ertn,
               csr_exception_type, csr_pc_in, csr_badv_we, csr_badv_data
    );

    modport slave (
        input  req_valid, req_op, req_pc, req_csr_num, req_rd_val, req_rj_val, req_badv,
               req_exc_adef, req_exc_ine, req_exc_ale, req_exc_adem, resp_ready,
               csr_rdata, csr_pc_out, csr_interrupt,
        output req_ready, resp_valid, resp_rd_val, resp_redirect, resp_target,
               csr_addr, csr_we, csr_wdata, csr_have_exception, csr_ertn,
               csr_exception_type, csr_pc_in, csr_badv_we, csr_badv_data
    );
endinterface

// File: rtl/csr_ctrl_exc_prio.sv
// Fixed-priority encoder from raw exception sources to a single exception code.
module csr_ctrl_exc_prio
    import csr_ctrl_pkg::*;
(
    input  logic       interrupt,
    input  logic       adef,
    input  logic       ine,
    input  logic       syscall,
    input  logic       brk,
    input  logic       ale,
    input  logic       adem,
    output logic       valid,
    output exception_t exc
);

    always_comb begin
        valid = 1'b1;
        exc   = mk_exc(ECODE_INT, ESUB_NONE);
        if (interrupt)    exc = mk_exc(ECODE_INT, ESUB_NONE);
        else if (adef)    exc = mk_exc(ECODE_ADE, ESUB_ADEF);
        else if (ine)     exc = mk_exc(ECODE_INE, ESUB_NONE);
        else if (syscall) exc = mk_exc(ECODE_SYS, ESUB_NONE);
        else if (brk)     exc = mk_exc(ECODE_BRK, ESUB_NONE);
        else if (ale)     exc = mk_exc(ECODE_ALE, ESUB_NONE);
        else if (adem)    exc = mk_exc(ECODE_ADE, ESUB_ADEM);
        else              valid = 1'b0;
    end

endmodule

// File: rtl/csr_ctrl.sv
// Commit-stage CSR controller: accepts one instruction, performs its CSR access or
// exception/ERTN handoff in a single EXEC cycle, then returns the result and redirect.
module csr_ctrl
    import csr_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    csr_ctrl_if.slave bus
);

    state_e               state;
    logic                 ready_q;
    req_op_e              op_q;
    logic [CSR_NUM_W-1:0] addr_q;
    logic [XLEN-1:0]      we_q;
    logic [XLEN-1:0]      wdata_q;
    logic                 have_exc_q;
    logic                 ertn_q;
    exception_t           exc_type_q;
    logic [XLEN-1:0]      pc_in_q;
    logic                 badv_we_q;
    logic [XLEN-1:0]      badv_data_q;
    logic                 resp_valid_q;
    logic [XLEN-1:0]      resp_rd_val_q;
    logic                 resp_redirect_q;
    logic [XLEN-1:0]      resp_target_q;

    logic       exc_valid;
    exception_t exc;
    logic       accept;
    logic       adef_hit;
    logic       badv_hit;

    // Interrupt is sampled together with the request, so later changes cannot affect it.
    csr_ctrl_exc_prio u_exc_prio (
        .interrupt (bus.csr_interrupt),
        .adef      (bus.req_exc_adef),
        .ine       (bus.req_exc_ine),
        .syscall   (bus.req_op == OP_SYSCALL),
        .brk       (bus.req_op == OP_BREAK),
        .ale       (bus.req_exc_ale),
        .adem      (bus.req_exc_adem),
        .valid     (exc_valid),
        .exc       (exc)
    );

    assign accept   = (state == S_IDLE) && ready_q && bus.req_valid;
    assign adef_hit = exc_valid && (exc.ecode == ECODE_ADE) && (exc.esubcode == ESUB_ADEF);
    assign badv_hit = exc_valid && ((exc.ecode == ECODE_ALE) || (exc.ecode == ECODE_ADE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            ready_q         <= 1'b0;
            op_q            <= OP_NONE;
            addr_q          <= '0;
            we_q            <= '0;
            wdata_q         <= '0;
            have_exc_q      <= 1'b0;
            ertn_q          <= 1'b0;
            exc_type_q      <= '0;
            pc_in_q         <= '0;
            badv_we_q       <= 1'b0;
            badv_data_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_rd_val_q   <= '0;
            resp_redirect_q <= 1'b0;
            resp_target_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        state       <= S_EXEC;
                        ready_q     <= 1'b0;
                        op_q        <= bus.req_op;
                        addr_q      <= bus.req_csr_num;
                        wdata_q     <= bus.req_rd_val;
                        pc_in_q     <= bus.req_pc;
                        have_exc_q  <= exc_valid || (bus.req_op == OP_ERTN);
                        ertn_q      <= !exc_valid && (bus.req_op == OP_ERTN);
                        exc_type_q  <= exc_valid ? exc : '0;
                        badv_we_q   <= badv_hit;
                        badv_data_q <= !badv_hit ? '0 : (adef_hit ? bus.req_pc : bus.req_badv);
                        if (!exc_valid && bus.req_op == OP_CSRWR)        we_q <= '1;
                        else if (!exc_valid && bus.req_op == OP_CSRXCHG) we_q <= bus.req_rj_val;
                        else                                             we_q <= '0;
                    end
                end
                S_EXEC: begin
                    state        <= S_RESP;
                    we_q         <= '0;
                    have_exc_q   <= 1'b0;
                    ertn_q       <= 1'b0;
                    exc_type_q   <= '0;
                    badv_we_q    <= 1'b0;
                    resp_valid_q <= 1'b1;
                    // Exceptions and ERTN both redirect to the vector the CSR file presents.
                    if (have_exc_q) begin
                        resp_rd_val_q   <= '0;
                        resp_redirect_q <= 1'b1;
                        resp_target_q   <= bus.csr_pc_out;
                    end else begin
                        case (op_q)
                            OP_CSRRD: begin
                                resp_rd_val_q   <= bus.csr_rdata;
                                resp_redirect_q <= 1'b0;
                                resp_target_q   <= '0;
                            end
                            OP_CSRWR, OP_CSRXCHG: begin
                                resp_rd_val_q   <= bus.csr_rdata;
                                resp_redirect_q <= 1'b1;
                                resp_target_q   <= pc_in_q + XLEN'(4);
                            end
                            default: begin
                                resp_rd_val_q   <= '0;
                                resp_redirect_q <= 1'b0;
                                resp_target_q   <= '0;
                            end
                        endcase
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        state        <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        ready_q      <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Reset masks the strobes immediately so an aborted EXEC leaves the CSR file untouched.
    assign bus.req_ready          = ready_q & ~reset;
    assign bus.csr_we             = we_q & {XLEN{~reset}};
    assign bus.csr_have_exception = have_exc_q & ~reset;
    assign bus.csr_ertn           = ertn_q & ~reset;
    assign bus.csr_badv_we        = badv_we_q & ~reset;
    assign bus.csr_addr           = addr_q;
    assign bus.csr_wdata          = wdata_q;
    assign bus.csr_exception_type = exc_type_q;
    assign bus.csr_pc_in          = pc_in_q;
    assign bus.csr_badv_data      = badv_data_q;
    assign bus.resp_valid         = resp_valid_q;
    assign bus.resp_rd_val        = resp_rd_val_q;
    assign bus.resp_redirect      = resp_redirect_q;
    assign bus.resp_target        = resp_target_q;

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed-vector bench for csr_ctrl with hand-computed expectations.
module tb_csr_ctrl;
    import csr_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    csr_ctrl_if bus();

    csr_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // values captured during EXEC and RESP of the last request
    logic [31:0] ex_we, ex_wdata, ex_pc_in, ex_badv_data, ex_addr, ex_type;
    logic        ex_have, ex_ertn, ex_badv_we, ex_ready, ex_rv;
    logic [31:0] rs_rd, rs_target, rs_we;
    logic        rs_valid, rs_redir, rs_have;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request starting at a negedge; returns at a negedge.
    task automatic send(input req_op_e op, input logic [13:0] num, input logic [31:0] pc,
                        input logic [31:0] rd, input logic [31:0] rj, input logic [31:0] badv,
                        input logic [3:0] flags, input logic intr,
                        input logic [31:0] rdata, input logic [31:0] pc_out);
        int n;
        bus.req_op      = op;
        bus.req_csr_num = num;
        bus.req_pc      = pc;
        bus.req_rd_val  = rd;
        bus.req_rj_val  = rj;
        bus.req_badv    = badv;
        {bus.req_exc_adef, bus.req_exc_ine, bus.req_exc_ale, bus.req_exc_adem} = flags;
        bus.csr_interrupt = intr;
        bus.csr_rdata     = rdata;
        bus.csr_pc_out    = pc_out;
        bus.req_valid     = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check_eq("ready_timeout", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid     = 1'b0;
        bus.csr_interrupt = ~intr;
        ex_we        = bus.csr_we;
        ex_wdata     = bus.csr_wdata;
        ex_pc_in     = bus.csr_pc_in;
        ex_badv_data = bus.csr_badv_data;
        ex_addr      = 32'(bus.csr_addr);
        ex_type      = 32'(bus.csr_exception_type);
        ex_have      = bus.csr_have_exception;
        ex_ertn      = bus.csr_ertn;
        ex_badv_we   = bus.csr_badv_we;
        ex_ready     = bus.req_ready;
        ex_rv        = bus.resp_valid;
        @(posedge clk);
        @(negedge clk);
        rs_valid  = bus.resp_valid;
        rs_rd     = bus.resp_rd_val;
        rs_redir  = bus.resp_redirect;
        rs_target = bus.resp_target;
        rs_we     = bus.csr_we;
        rs_have   = bus.csr_have_exception;
        bus.csr_interrupt = 1'b0;
        if (bus.resp_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic expect_exec(input string tag, input logic [31:0] we, input logic [31:0] wdata,
                               input logic have, input logic ertn, input logic [31:0] etype,
                               input logic badv_we, input logic [31:0] badv_data);
        check_eq({tag, ".we"},       ex_we, we);
        check_eq({tag, ".wdata"},    ex_wdata, wdata);
        check_eq({tag, ".have_exc"}, 32'(ex_have), 32'(have));
        check_eq({tag, ".ertn"},     32'(ex_ertn), 32'(ertn));
        check_eq({tag, ".exc_type"}, ex_type, etype);
        check_eq({tag, ".badv_we"},  32'(ex_badv_we), 32'(badv_we));
        if (badv_we) check_eq({tag, ".badv_data"}, ex_badv_data, badv_data);
        check_eq({tag, ".exec_ready"}, 32'(ex_ready), 32'd0);
        check_eq({tag, ".exec_rvalid"}, 32'(ex_rv), 32'd0);
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] rd,
                               input logic redir, input logic [31:0] target);
        check_eq({tag, ".resp_valid"}, 32'(rs_valid), 32'd1);
        check_eq({tag, ".rd_val"},     rs_rd, rd);
        check_eq({tag, ".redirect"},   32'(rs_redir), 32'(redir));
        if (redir) check_eq({tag, ".target"}, rs_target, target);
        check_eq({tag, ".resp_we"},    rs_we, 32'd0);
        check_eq({tag, ".resp_have"},  32'(rs_have), 32'd0);
    endtask

    logic [31:0] held_rd, held_target;
    logic        held_redir;

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op = OP_NONE;
        bus.req_csr_num = '0;
        bus.req_pc = '0;
        bus.req_rd_val = '0;
        bus.req_rj_val = '0;
        bus.req_badv = '0;
        {bus.req_exc_adef, bus.req_exc_ine, bus.req_exc_ale, bus.req_exc_adem} = 4'b0;
        bus.resp_ready = 1'b1;
        bus.csr_rdata = '0;
        bus.csr_pc_out = '0;
        bus.csr_interrupt = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst.req_ready",  32'(bus.req_ready), 32'd0);
        check_eq("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst.csr_we",     bus.csr_we, 32'd0);
        check_eq("rst.csr_addr",   32'(bus.csr_addr), 32'd0);
        check_eq("rst.have_exc",   32'(bus.csr_have_exception), 32'd0);
        check_eq("rst.badv_we",    32'(bus.csr_badv_we), 32'd0);
        check_eq("rst.rd_val",     bus.resp_rd_val, 32'd0);
        check_eq("rst.target",     bus.resp_target, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_rst.req_ready", 32'(bus.req_ready), 32'd1);

        // CSRRD; interrupt rising after accept must be ignored
        send(OP_CSRRD, 14'h30, 32'h1C00_0000, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h1234_5678, 32'h0);
        check_eq("rd.addr", ex_addr, 32'h30);
        expect_exec("rd", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_resp("rd", 32'h1234_5678, 1'b0, 32'h0);

        send(OP_CSRXCHG, 14'h00, 32'h1C00_0010, 32'h7, 32'h3, 32'h0, 4'b0000, 1'b0, 32'hB, 32'h0);
        expect_exec("xchg", 32'h3, 32'h7, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_resp("xchg", 32'hB, 1'b1, 32'h1C00_0014);

        send(OP_SYSCALL, 14'h00, 32'h1C00_0100, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h1C00_8000);
        check_eq("sys.pc_in", ex_pc_in, 32'h1C00_0100);
        expect_exec("sys", 32'h0, 32'h0, 1'b1, 1'b0, 32'h1600, 1'b0, 32'h0);
        expect_resp("sys", 32'h0, 1'b1, 32'h1C00_8000);

        // interrupt beats ALE and suppresses the write
        send(OP_CSRWR, 14'h05, 32'h1C00_0020, 32'hAA, 32'h0, 32'h8000_0003, 4'b0010, 1'b1, 32'h55, 32'h1C00_9000);
        expect_exec("int", 32'h0, 32'hAA, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_resp("int", 32'h0, 1'b1, 32'h1C00_9000);

        send(OP_NONE, 14'h00, 32'h1C00_0030, 32'h0, 32'h0, 32'h8000_0003, 4'b0010, 1'b0, 32'h0, 32'h1C00_8000);
        expect_exec("ale", 32'h0, 32'h0, 1'b1, 1'b0, 32'h1200, 1'b1, 32'h8000_0003);
        expect_resp("ale", 32'h0, 1'b1, 32'h1C00_8000);

        send(OP_ERTN, 14'h00, 32'h1C00_0040, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h1C00_0400);
        expect_exec("ertn", 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
        expect_resp("ertn", 32'h0, 1'b1, 32'h1C00_0400);

        // ADEF outranks INE and records the pc as bad address
        send(OP_CSRRD, 14'h01, 32'h1C00_0202, 32'h0, 32'h0, 32'h1111, 4'b1100, 1'b0, 32'h99, 32'h1C00_8000);
        expect_exec("adef", 32'h0, 32'h0, 1'b1, 1'b0, 32'h1000, 1'b1, 32'h1C00_0202);
        expect_resp("adef", 32'h0, 1'b1, 32'h1C00_8000);

        send(OP_NONE, 14'h00, 32'h1C00_0050, 32'h0, 32'h0, 32'h0000_2222, 4'b0001, 1'b0, 32'h0, 32'h1C00_8000);
        expect_exec("adem", 32'h0, 32'h0, 1'b1, 1'b0, 32'h1001, 1'b1, 32'h0000_2222);

        send(OP_BREAK, 14'h00, 32'h1C00_0060, 32'h0, 32'h0, 32'h0, 4'b0100, 1'b0, 32'h0, 32'h1C00_8000);
        expect_exec("ine", 32'h0, 32'h0, 1'b1, 1'b0, 32'h1A00, 1'b0, 32'h0);

        send(OP_BREAK, 14'h00, 32'h1C00_0070, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h1C00_8000);
        expect_exec("brk", 32'h0, 32'h0, 1'b1, 1'b0, 32'h1800, 1'b0, 32'h0);

        // CSRWR at top of address space: pc+4 wraps to 0
        send(OP_CSRWR, 14'h3FFF, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'b0000, 1'b0, 32'hCAFE, 32'h0);
        check_eq("wr.addr", ex_addr, 32'h3FFF);
        expect_exec("wr", 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_resp("wr", 32'hCAFE, 1'b1, 32'h0);

        send(OP_CSRXCHG, 14'h02, 32'h1C00_0080, 32'h5, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h77, 32'h0);
        expect_exec("xchg0", 32'h0, 32'h5, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_resp("xchg0", 32'h77, 1'b1, 32'h1C00_0084);

        send(OP_NONE, 14'h00, 32'h1C00_0090, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0, 32'h0);
        expect_exec("none", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_resp("none", 32'h0, 1'b0, 32'h0);

        // back-pressure: payload must hold while resp_ready is low
        bus.resp_ready = 1'b0;
        send(OP_CSRRD, 14'h10, 32'h1C00_00A0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'hABCD_0001, 32'h0);
        expect_resp("stall", 32'hABCD_0001, 1'b0, 32'h0);
        held_rd = rs_rd; held_redir = rs_redir; held_target = rs_target;
        bus.csr_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall.valid",  32'(bus.resp_valid), 32'd1);
            check_eq("stall.ready",  32'(bus.req_ready), 32'd0);
            check_eq("stall.rd_val", bus.resp_rd_val, held_rd);
            check_eq("stall.redir",  32'(bus.resp_redirect), 32'(held_redir));
            check_eq("stall.target", bus.resp_target, held_target);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("stall.release_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("stall.release_ready", 32'(bus.req_ready), 32'd1);

        // reset while in EXEC of a CSRWR
        bus.req_op = OP_CSRWR;
        bus.req_csr_num = 14'h7;
        bus.req_rd_val = 32'h1;
        {bus.req_exc_adef, bus.req_exc_ine, bus.req_exc_ale, bus.req_exc_adem} = 4'b0;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rstexec.we",       bus.csr_we, 32'd0);
        check_eq("rstexec.have_exc", 32'(bus.csr_have_exception), 32'd0);
        check_eq("rstexec.ready",    32'(bus.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("rstexec.resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rstexec.addr",       32'(bus.csr_addr), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rstexec.idle_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rstexec.idle_we",    bus.csr_we, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
